sll_pipe: RTL and testbench
===========================

// Module: sll_pipe
// PURPOSE
//  Pipelined logical left barrel shifter: the left-direction counterpart of the ALU's
//  arithmetic right shifter. Decomposes shamt into log2 stages (1,2,4,8,16), one
//  register stage per bit, zero-filling from the LSB.
//  Sits between ALU operand select and the writeback mux, with valid/ready on both sides.
//  Also reports overflow: a nonzero bit was shifted out past the MSB.
// PARAMETERS
//  WIDTH    32  data width; must equal 2**SHAMT_W
//  SHAMT_W  5   shift-amount width = number of pipeline stages
// PORTS
//  clock      in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  in_valid   in   1        operand/shamt valid
//  in_ready   out  1        block can accept this cycle
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount, unsigned 0..WIDTH-1
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_data   out  WIDTH    in_data << in_shamt, zero filled
//  out_ovf    out  1        1 if any 1-bit was discarded off the MSB
// BEHAVIOUR
//  - Reset (async, any time): all stage valid bits, data, shamt and ovf regs clear to 0;
//    out_valid=0, out_data=0, out_ovf=0 immediately; in-flight ops are dropped.
//  - Stage k (k=0..SHAMT_W-1) registers: v[k], d[k], s[k] (remaining shamt), o[k] (sticky ovf).
//    If shamt bit k is set: d = d_prev << 2**k, o = o_prev | (|d_prev[WIDTH-1 -: 2**k]).
//    Otherwise d and o pass through unchanged.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv (combinational).
//    When adv=1, every stage loads from its predecessor; stage 0 loads in_valid/data/shamt.
//    When adv=0, all stages hold; out_data/out_ovf are stable while out_valid=1 && !out_ready.
//  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
//  - Latency: SHAMT_W cycles from input acceptance to out_valid, with no stalls.
//    Throughput: 1 op/cycle. Results leave in issue order; no reordering.
//  - Bubbles: an in_valid=0 cycle with adv=1 injects v=0. Data regs of bubbles are don't-care
//    internally, but out_data must read 0 when out_valid=0.
//  - Simultaneous accept + emit with full pipe and out_ready=1: both occur, no loss.
//  - shamt=0: out_data=in_data, out_ovf=0. Max shift is WIDTH-1; shamt width forbids >=WIDTH.
//  - No other state machine: the pipeline is a valid-shift register under adv control.
// STRUCTURE
//  - Shared include alu_defs.vh: `define ALU_WIDTH 32, `define ALU_SHAMT_W 5,
//    shared with the right-shift unit.
//  - One sub-module sll_stage #(WIDTH, SHAMT_W, K): combinational conditional shift by 2**K,
//    ovf accumulate, and async-reset pipeline register with enable=adv.
//    Instantiated SHAMT_W times via generate.
//  - Top level: the adv/in_ready logic and output gating only.
// TESTING
//  1. in=0x0000_0001, shamt=31, out_ready=1 -> after 5 cycles out_data=0x8000_0000, ovf=0.
//  2. in=0xFFFF_FFFF, shamt=4 -> out_data=0xFFFF_FFF0, ovf=1.
//     Also in=0x0FFF_FFFF, shamt=4 -> out_data=0xFFFF_FFF0, ovf=0.
//  3. in=0xDEAD_BEEF, shamt=0 -> out_data=0xDEAD_BEEF, ovf=0.
//  4. 8 back-to-back ops with shamt=0..7 on in=0x1, out_ready=1 -> out_valid high for 8
//     consecutive cycles starting cycle 5; results 0x1,0x2,...,0x80 in order.
//  5. Fill pipe, drop out_ready for 3 cycles -> in_ready=0 those cycles, out_data held
//     constant. On release, all 5 results drain in order, no duplicates or loss.
//  6. Assert reset mid-stream with 3 ops in flight -> out_valid=0, out_data=0 in the same
//     cycle. After release, the first new op's result appears 5 cycles after acceptance.
//  Scoreboard: reference model ((in<<sh) & mask, |(in>>(WIDTH-sh))), random shamt/data,
//  random out_ready.

Source files
------------

// File: rtl/sll_pipe_pkg.sv
// Shared definitions for the logical-left shift pipeline.
// ALU_WIDTH / ALU_SHAMT_W mirror the datapath sizing used by the right-shift unit,
// so both shifters elaborate with the same defaults.
package sll_pipe_pkg;

  localparam int unsigned ALU_WIDTH   = 32;
  localparam int unsigned ALU_SHAMT_W = 5;

  // Shift distance handled by pipeline stage k.
  function automatic int unsigned stage_dist(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One stage of the left barrel shifter.
// Conditionally shifts by 2**K (selected by bit K of the remaining shift amount),
// accumulates the sticky overflow flag, and registers the result when adv=1.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   adv               pipeline advance enable (global)
//   v_prev/d_prev/s_prev/o_prev  valid, data, shift amount, overflow from predecessor
//   v/d/s/o           registered stage outputs
module sll_stage
  import sll_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W,
  parameter int unsigned K       = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               adv,
  input  logic               v_prev,
  input  logic [WIDTH-1:0]   d_prev,
  input  logic [SHAMT_W-1:0] s_prev,
  input  logic               o_prev,
  output logic               v,
  output logic [WIDTH-1:0]   d,
  output logic [SHAMT_W-1:0] s,
  output logic               o
);

  localparam int unsigned DIST = stage_dist(K);

  logic [WIDTH-1:0] d_next;
  logic             o_next;

  always_comb begin
    d_next = d_prev;
    o_next = o_prev;
    if (s_prev[K]) begin
      d_next = d_prev << DIST;
      // Any 1 in the top DIST bits is lost by this stage's shift.
      o_next = o_prev | (|d_prev[WIDTH-1 -: DIST]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
      s <= '0;
      o <= 1'b0;
    end else if (adv) begin
      v <= v_prev;
      d <= d_next;
      s <= s_prev;
      o <= o_next;
    end
  end

endmodule

// File: rtl/sll_pipe.sv
// Pipelined logical left barrel shifter with overflow detect.
// SHAMT_W register stages, stage k shifting by 2**k; zero fill from the LSB.
// A single global stall (adv) freezes every stage when the output is blocked.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake; in_ready = !out_valid | out_ready
//   in_data, in_shamt     operand and shift amount (0..WIDTH-1)
//   out_valid/out_ready   output handshake
//   out_data              in_data << in_shamt, forced to 0 when out_valid=0
//   out_ovf               1 if a 1-bit was shifted out past the MSB (0 when idle)
module sll_pipe
  import sll_pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf
);

  logic adv;

  // Element 0 is the pipeline input; element k+1 is stage k's register.
  logic               v_c [0:SHAMT_W];
  logic [WIDTH-1:0]   d_c [0:SHAMT_W];
  logic               o_c [0:SHAMT_W];
  logic [SHAMT_W-1:0] s_c [0:SHAMT_W-1];

  assign v_c[0] = in_valid;
  assign d_c[0] = in_data;
  assign o_c[0] = 1'b0;
  assign s_c[0] = in_shamt;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic [SHAMT_W-1:0] s_out;

    sll_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .K      (k)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .adv   (adv),
      .v_prev(v_c[k]),
      .d_prev(d_c[k]),
      .s_prev(s_c[k]),
      .o_prev(o_c[k]),
      .v     (v_c[k+1]),
      .d     (d_c[k+1]),
      .s     (s_out),
      .o     (o_c[k+1])
    );

    // The last stage's remaining shift amount has no consumer.
    if (k < SHAMT_W - 1) begin : g_fwd
      assign s_c[k+1] = s_out;
    end else begin : g_last
      logic [SHAMT_W-1:0] s_unused;
      assign s_unused = s_out;
    end
  end

  assign out_valid = v_c[SHAMT_W];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;

  // Bubble data is don't-care internally; hide it at the boundary.
  assign out_data  = out_valid ? d_c[SHAMT_W] : '0;
  assign out_ovf   = out_valid & o_c[SHAMT_W];

endmodule

// File: tb/tb_sll_pipe.sv
module tb_sll_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  int tests = 0;
  int fails = 0;

  logic [W:0] exp_q [$];   // {ovf, data} in issue order

  always #5 clock = ~clock;

  sll_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  // Reference: do the shift in double width; whatever lands in the upper half was lost.
  function automatic logic [W:0] model(input logic [W-1:0] din, input logic [SW-1:0] sh);
    logic [2*W-1:0] wide;
    wide = {{W{1'b0}}, din} << sh;
    return {|wide[2*W-1:W], wide[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare process: scoreboard, idle-zero and stall-hold checks every cycle.
  initial begin
    logic          stall_seen;
    logic [W-1:0]  held_data;
    logic          held_ovf;
    logic [W:0]    e;
    stall_seen = 1'b0;
    held_data  = '0;
    held_ovf   = 1'b0;
    forever begin
      @(negedge clock);
      if (!out_valid) check("idle_zero", {31'd0, out_ovf, out_data}, 64'd0);
      if (reset) begin
        exp_q.delete();
        stall_seen = 1'b0;
      end else begin
        if (stall_seen)
          check("stall_hold", {out_valid, out_ovf, out_data}, {1'b1, held_ovf, held_data});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got data %0h with no expected entry", out_data);
          end else begin
            e = exp_q.pop_front();
            check("scoreboard", {31'd0, out_ovf, out_data}, {31'd0, e});
          end
        end
        stall_seen = out_valid && !out_ready;
        held_data  = out_data;
        held_ovf   = out_ovf;
        if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt));
      end
    end
  end

  // Issue one op into an empty pipe and measure cycles until out_valid.
  task automatic send_and_wait(input string name, input logic [W-1:0] din,
                               input logic [SW-1:0] sh, input logic [W-1:0] ed,
                               input logic eo);
    int n;
    n = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = din; in_shamt = sh; out_ready = 1'b1;
    do begin
      @(posedge clock);
      n++;
      if (n == 1) begin #1; in_valid = 1'b0; end
      @(negedge clock);
    end while (!out_valid && n < 20);
    check({name, "_lat"}, n, 5);
    check({name, "_data"}, out_data, ed);
    check({name, "_ovf"}, out_ovf, eo);
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Hand-computed single ops (pin the model as well as the DUT).
    send_and_wait("msb", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    send_and_wait("ovf1", 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b1);
    send_and_wait("ovf0", 32'h0FFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b0);
    send_and_wait("sh0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
    send_and_wait("ovf_hi", 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1);

    // 8 back-to-back ops, shamt 0..7 on 0x1.
    for (int t = 0; t < 16; t++) begin
      @(posedge clock); #1;
      in_valid = (t < 8); in_data = 32'h1; in_shamt = t[SW-1:0]; out_ready = 1'b1;
      @(negedge clock);
      if (t >= 5 && t < 13) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_data", out_data, 32'h1 << (t - 5));
      end else begin
        check("b2b_valid", out_valid, 0);
      end
    end

    // Fill the pipe with 5 ops, stall the output for 3 cycles, then drain.
    for (int t = 0; t < 15; t++) begin
      @(posedge clock); #1;
      in_valid = (t < 5); in_data = 32'h3; in_shamt = SW'(t + 1);
      out_ready = !(t >= 5 && t < 8);
      @(negedge clock);
      if (t >= 5 && t < 8) check("stall_in_ready", in_ready, 0);
      if (t >= 5 && t <= 8) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 32'h6);
      end else if (t >= 9 && t <= 12) begin
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, 32'h3 << (t - 7));
      end else begin
        check("drain_valid", out_valid, 0);
      end
    end

    // Reset mid-stream with results emerging and ops in flight.
    for (int t = 0; t < 6; t++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; in_data = W'(t + 1); in_shamt = 5'd2; out_ready = 1'b1;
    end
    @(negedge clock);
    check("pre_rst_valid", out_valid, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    send_and_wait("post_rst", 32'h0000_0005, 5'd3, 32'h0000_0028, 1'b0);

    // Random traffic against the scoreboard, with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      in_shamt  = SW'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid); i++) @(negedge clock);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
